bp_me_burst_to_lite_reassembler: RTL and testbench

// - Receiver end of the BedRock burst link: accepts a header beat plus N data beats (ready&valid).
// - Reassembles them into one lite message {data, header} with the full block of data (valid->yumi).
// - Sits between the CCE burst outputs (lce_cmd, mem_cmd) and lite consumers in ME testbenches
//   (mock LCE, bp_mem).
// - Strictly single-buffered: one message in flight.

---
 rtl/bp_me_burst_to_lite_reassembler.sv | 210 +++++++++++++++++++++
 tb/tb_bp_me_burst_to_lite_reassembler.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_burst_to_lite_reassembler.sv
// bp_me_burst_to_lite_reassembler
//   Receiver end of a BedRock burst link. It collects one header beat and the
//   data beats that follow it, then presents the whole message as a single lite
//   message {data, header}. Only one message is held at a time.
//
// Ports
//   clk_i, reset_i       clock; asynchronous active-high reset
//   header_i/_v_i        burst header and its valid
//   header_has_data_i    header is followed by data beats
//   header_ready_o       header can be taken (idle only)
//   data_i/_v_i          burst data beat and its valid
//   data_ready_o         data beat can be taken (collecting beats only)
//   msg_o, v_o           reassembled lite message and its valid
//   yumi_i               consumer takes msg_o this cycle

module bp_me_burst_to_lite_reassembler #(
  parameter int header_width_p   = 64,
  parameter int in_data_width_p  = 64,
  parameter int out_data_width_p = 512,
  parameter int size_lsb_p       = 0
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic [header_width_p-1:0]                  header_i,
  input  logic                                       header_v_i,
  input  logic                                       header_has_data_i,
  output logic                                       header_ready_o,
  input  logic [in_data_width_p-1:0]                 data_i,
  input  logic                                       data_v_i,
  output logic                                       data_ready_o,
  output logic [header_width_p+out_data_width_p-1:0] msg_o,
  output logic                                       v_o,
  input  logic                                       yumi_i
);

  localparam int ratio_lp     = out_data_width_p / in_data_width_p;
  localparam int cnt_width_lp = $clog2(ratio_lp) + 1;
  localparam int idx_width_lp = $clog2(out_data_width_p);

  typedef enum logic [1:0] {
    e_ready = 2'd0,
    e_data  = 2'd1,
    e_send  = 2'd2
  } state_e;

  state_e                      state_r, state_next_s;
  logic [header_width_p-1:0]   header_r;
  logic                        has_data_r;
  logic [cnt_width_lp-1:0]     count_r;
  logic [cnt_width_lp-1:0]     beats_r;
  logic [cnt_width_lp-1:0]     beats_s;
  logic [out_data_width_p-1:0] data_r;
  logic [out_data_width_p-1:0] data_fill_s;

  // Number of burst beats a header announces; a block narrower than one beat
  // still travels in one beat.
  function automatic logic [cnt_width_lp-1:0] beats_f(input logic [2:0] size,
                                                      input logic       has_data);
    int beat_cnt;
    beat_cnt = (32'sd8 << size) / in_data_width_p;
    if (!has_data) begin
      beats_f = '0;
    end else if (beat_cnt < 32'sd1) begin
      beats_f = cnt_width_lp'(1'b1);
    end else begin
      beats_f = cnt_width_lp'(beat_cnt);
    end
  endfunction

  assign beats_s = beats_f(header_i[size_lsb_p +: 3], header_has_data_i);

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_ready;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and handshake outputs; readies depend on state only.
  always_comb begin
    state_next_s   = state_r;
    header_ready_o = 1'b0;
    data_ready_o   = 1'b0;
    v_o            = 1'b0;
    case (state_r)
      e_ready: begin
        // state_r already sits in e_ready during reset, so gate the ready.
        header_ready_o = ~reset_i;
        if (header_v_i) begin
          if (beats_s == '0) begin
            state_next_s = e_send;
          end else begin
            state_next_s = e_data;
          end
        end else begin
          state_next_s = e_ready;
        end
      end
      e_data: begin
        data_ready_o = 1'b1;
        if (data_v_i && (count_r == beats_r - cnt_width_lp'(1'b1))) begin
          state_next_s = e_send;
        end else begin
          state_next_s = e_data;
        end
      end
      e_send: begin
        v_o = 1'b1;
        if (yumi_i) begin
          state_next_s = e_ready;
        end else begin
          state_next_s = e_send;
        end
      end
      default: begin
        state_next_s = e_ready;
      end
    endcase
  end

  // Header capture and beat collection.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      header_r   <= '0;
      has_data_r <= 1'b0;
      beats_r    <= '0;
      count_r    <= '0;
      data_r     <= '0;
    end else if ((state_r == e_ready) && header_v_i) begin
      header_r   <= header_i;
      has_data_r <= header_has_data_i;
      beats_r    <= beats_s;
      count_r    <= '0;
    end else if ((state_r == e_data) && data_v_i) begin
      for (int k = 0; k < ratio_lp; k++) begin
        if (count_r == cnt_width_lp'(k)) begin
          data_r[k*in_data_width_p +: in_data_width_p] <= data_i;
        end
      end
      count_r <= count_r + cnt_width_lp'(1'b1);
    end
  end

  // Replicate the low block-size bits of the collected data across the lite
  // data field. Block sizes are powers of two, so the wrap is a bit mask.
  always_comb begin
    int                      fill_bits;
    logic [idx_width_lp-1:0] fill_mask;
    logic [idx_width_lp-1:0] idx;
    data_fill_s = '0;
    fill_bits   = 32'sd8 << header_r[size_lsb_p +: 3];
    idx         = '0;
    if (fill_bits >= out_data_width_p) begin
      fill_mask = '1;
    end else begin
      fill_mask = idx_width_lp'(fill_bits - 32'sd1);
    end
    if (has_data_r) begin
      for (int i = 0; i < out_data_width_p; i++) begin
        idx            = idx_width_lp'(i) & fill_mask;
        data_fill_s[i] = data_r[idx];
      end
    end else begin
      data_fill_s = '0;
    end
  end

  assign msg_o = {data_fill_s, header_r};

  bp_me_burst_to_lite_reassembler_checker #(
    .out_data_width_p(out_data_width_p)
  ) checker_inst (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .header_v_i       (header_v_i),
    .header_ready_o   (header_ready_o),
    .header_has_data_i(header_has_data_i),
    .header_size_i    (header_i[size_lsb_p +: 3]),
    .v_o              (v_o),
    .yumi_i           (yumi_i)
  );

endmodule

// Usage checks for the reassembler: the consumer must only take a message that
// is offered, and a data-carrying header must not announce more data than the
// lite data field holds.
module bp_me_burst_to_lite_reassembler_checker #(
  parameter int out_data_width_p = 512
) (
  input logic       clk_i,
  input logic       reset_i,
  input logic       header_v_i,
  input logic       header_ready_o,
  input logic       header_has_data_i,
  input logic [2:0] header_size_i,
  input logic       v_o,
  input logic       yumi_i
);

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    yumi_i |-> v_o);

  size_fits_lite: assert property (@(posedge clk_i) disable iff (reset_i)
    (header_v_i && header_ready_o && header_has_data_i)
      |-> ((32'sd8 << header_size_i) <= out_data_width_p));

endmodule

// File: tb/tb_bp_me_burst_to_lite_reassembler.sv
module tb_bp_me_burst_to_lite_reassembler;

  localparam int HW = 64;
  localparam int IW = 64;
  localparam int OW = 512;
  localparam int SL = 0;
  localparam int MW = HW + OW;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [HW-1:0] header_i = '0;
  logic          header_v_i = 1'b0;
  logic          header_has_data_i = 1'b0;
  logic          header_ready_o;
  logic [IW-1:0] data_i = '0;
  logic          data_v_i = 1'b0;
  logic          data_ready_o;
  logic [MW-1:0] msg_o;
  logic          v_o;
  logic          yumi_i = 1'b0;

  bp_me_burst_to_lite_reassembler #(
    .header_width_p(HW), .in_data_width_p(IW), .out_data_width_p(OW), .size_lsb_p(SL)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .header_i(header_i), .header_v_i(header_v_i), .header_has_data_i(header_has_data_i),
    .header_ready_o(header_ready_o),
    .data_i(data_i), .data_v_i(data_v_i), .data_ready_o(data_ready_o),
    .msg_o(msg_o), .v_o(v_o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0]   vcyc;
    logic [MW-1:0] msg;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_sent = 0;
  int   n_recv = 0;
  int   hold_cfg = 0;
  bit   holding = 1'b0;

  task automatic check_m(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_i(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: beat count and the lite data field, built byte by byte.
  function automatic int model_beats(input logic [2:0] size, input logic hd);
    int nbits;
    nbits = 8 * (1 << size);
    if (!hd) return 0;
    if (nbits < IW) return 1;
    return nbits / IW;
  endfunction

  function automatic logic [OW-1:0] model_data(input logic [2:0] size, input logic hd,
                                               input logic [IW-1:0] beats[$]);
    logic [7:0]    blk[$];
    logic [IW-1:0] w;
    logic [OW-1:0] r;
    int            nbytes;
    r = '0;
    if (hd) begin
      nbytes = 1 << size;
      for (int b = 0; b < nbytes; b++) begin
        w = beats[b / (IW/8)];
        blk.push_back(w[(b % (IW/8))*8 +: 8]);
      end
      for (int i = 0; i < OW/8; i++) r[i*8 +: 8] = blk[i % nbytes];
    end
    return r;
  endfunction

  task automatic handshake(input bit is_hdr, output bit ok);
    bit rdy;
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk_i);
      rdy = is_hdr ? header_ready_o : data_ready_o;
      @(posedge clk_i);
      ok = rdy;
    end
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: %s ready not seen in 400 cycles", is_hdr ? "header" : "data");
    end
  endtask

  task automatic send_msg(input logic [2:0] size, input logic hd, input int gap_mode,
                          input int abort_after, input logic [IW-1:0] fixed[$]);
    logic [HW-1:0] h;
    logic [IW-1:0] beats[$];
    int            nb;
    int            gap;
    bit            ok;
    exp_t          e;
    h = {$urandom(), $urandom()};
    h[SL +: 3] = size;
    nb = model_beats(size, hd);
    for (int k = 0; k < nb; k++) beats.push_back(k < fixed.size() ? fixed[k] : {$urandom(), $urandom()});
    header_i = h;
    header_has_data_i = hd;
    header_v_i = 1'b1;
    handshake(1'b1, ok);
    header_v_i = 1'b0;
    header_i = {$urandom(), $urandom()};
    header_has_data_i = 1'($urandom_range(0, 1));
    for (int k = 0; k < nb; k++) begin
      gap = 0;
      if (k > 0 && gap_mode == 1) gap = 1;
      else if (k > 0 && gap_mode == 2 && $urandom_range(0, 3) == 0) gap = int'($urandom_range(1, 2));
      data_v_i = 1'b0;
      data_i = {$urandom(), $urandom()};
      repeat (gap) begin @(posedge clk_i); #1; end
      data_i = beats[k];
      data_v_i = 1'b1;
      handshake(1'b0, ok);
      data_v_i = 1'b0;
      data_i = {$urandom(), $urandom()};
      if (abort_after == k + 1) begin
        reset_i = 1'b1;
        return;
      end
    end
    e.msg  = {model_data(size, hd, beats), h};
    e.vcyc = 32'(cyc);
    exp_q.push_back(e);
    n_sent++;
  endtask

  task automatic drain();
    for (int t = 0; t < 500 && (exp_q.size() != 0 || holding); t++) @(posedge clk_i);
    #1;
  endtask

  // Monitor / consumer: pops the scoreboard when a message appears.
  initial begin : monitor
    exp_t          e;
    logic [MW-1:0] cap;
    int            hold;
    bit            exp_rdy;
    hold = 0;
    exp_rdy = 1'b0;
    cap = '0;
    forever begin
      @(negedge clk_i);
      yumi_i = 1'b0;
      if (reset_i) begin
        check_i("reset_header_ready", int'(header_ready_o), 0);
        check_i("reset_data_ready", int'(data_ready_o), 0);
        check_i("reset_v", int'(v_o), 0);
        check_m("reset_msg", msg_o, '0);
        holding = 1'b0;
        exp_rdy = 1'b0;
      end else begin
        if (exp_rdy) begin
          check_i("ready_after_yumi", int'(header_ready_o), 1);
          exp_rdy = 1'b0;
        end
        if (v_o) begin
          check_i("header_ready_in_send", int'(header_ready_o), 0);
          check_i("data_ready_in_send", int'(data_ready_o), 0);
          if (!holding) begin
            holding = 1'b1;
            cap = msg_o;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_msg: v_o=1 msg %0h with nothing outstanding", msg_o);
              hold = 0;
            end else begin
              e = exp_q.pop_front();
              check_m("msg", msg_o, e.msg);
              check_i("v_latency_cycle", cyc, int'(e.vcyc));
              n_recv++;
              if (hold_cfg < 0) hold = int'($urandom_range(0, 3));
              else hold = hold_cfg;
            end
          end else begin
            check_m("msg_stable", msg_o, cap);
          end
          if (hold == 0) begin
            yumi_i = 1'b1;
            holding = 1'b0;
            exp_rdy = 1'b1;
          end else begin
            hold--;
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [IW-1:0] none[$];
    logic [IW-1:0] seq[$];
    logic [IW-1:0] one[$];
    logic [2:0]    sz;
    logic          hd;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;

    // Stray data while idle must not be taken.
    data_v_i = 1'b1;
    data_i = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk_i);
    check_i("data_ready_idle", int'(data_ready_o), 0);
    @(posedge clk_i);
    #1 data_v_i = 1'b0;

    hold_cfg = 0;
    send_msg(3'd3, 1'b0, 0, -1, none);
    for (int k = 0; k < 8; k++) seq.push_back(64'(k));
    send_msg(3'd6, 1'b1, 0, -1, seq);
    one.push_back(64'hDEADBEEF_CAFEF00D);
    send_msg(3'd3, 1'b1, 0, -1, one);
    drain();

    hold_cfg = 5;
    send_msg(3'd6, 1'b1, 1, -1, none);
    drain();
    hold_cfg = 0;

    // Reset after the third of eight beats; only the follow-up message may appear.
    send_msg(3'd6, 1'b1, 0, 3, none);
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
    send_msg(3'd3, 1'b1, 0, -1, none);
    drain();

    hold_cfg = -1;
    for (int m = 0; m < 1000; m++) begin
      sz = 3'($urandom_range(0, 6));
      hd = 1'($urandom_range(0, 1));
      send_msg(sz, hd, 2, -1, none);
    end
    drain();
    repeat (2) @(posedge clk_i);

    check_i("sent_vs_received", n_recv, n_sent);
    check_i("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
